// File: rtl/tile_skew_feeder.sv
// tile_skew_feeder: pops one SIZE x SIZE tile from tile_fifo and streams it
// into the left edge of the systolic array in diagonal (skewed) order.
// Lane r carries tile row r, delayed r steps, so element [r][k] appears on
// lane r at stream step k+r. One tile takes 2*SIZE-1 stream steps.

// Per-lane decode: selects row element k = step - ROW when it is in range.
module tile_skew_lane #(
    parameter int SIZE   = 2,
    parameter int STEP_W = 2,
    parameter int ROW    = 0
) (
    input  logic                    en,
    input  logic [STEP_W-1:0]       step,
    input  logic [SIZE-1:0][7:0]    row,
    output logic                    vld,
    output logic [7:0]              data
);

    logic signed [STEP_W:0] k;

    // Signed offset at STEP_W+1 bits so lanes ahead of the wavefront go negative.
    always_comb begin
        k    = $signed({1'b0, step}) - $signed((STEP_W+1)'(ROW));
        vld  = 1'b0;
        data = '0;
        if (en && (k >= 0) && (k < $signed((STEP_W+1)'(SIZE)))) begin
            vld = 1'b1;
            for (int i = 0; i < SIZE; i++) begin
                if (k == $signed((STEP_W+1)'(i))) data = row[i];
            end
        end
    end

endmodule

module tile_skew_feeder #(
    parameter int SIZE   = 2,
    parameter int STEP_W = $clog2(2*SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             pop,
    input  logic                             pop_rdy,
    input  logic [SIZE-1:0][SIZE-1:0][7:0]   tile_in,
    input  logic                             stall,
    output logic [SIZE-1:0][7:0]             lane_data,
    output logic [SIZE-1:0]                  lane_valid,
    output logic                             tile_first,
    output logic                             tile_last,
    output logic                             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] LAST = STEP_W'(2*SIZE-2);

    state_t                           state_q, state_d;
    logic [STEP_W-1:0]                step_q, step_d;
    logic [SIZE-1:0][SIZE-1:0][7:0]   tile_q, tile_d;
    logic                             streaming;

    // Pop only from IDLE; gated by rst_n so the port reads 0 while held in reset.
    assign pop       = rst_n && (state_q == IDLE) && pop_rdy && !stall;
    assign streaming = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign tile_first = streaming && (step_q == '0);
    assign tile_last  = streaming && (step_q == LAST);

    // Next-state: capture in WAIT regardless of stall, advance in STREAM unless stalled.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tile_d  = tile_q;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = WAIT;
            end
            WAIT: begin
                tile_d  = tile_in;
                step_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (!stall) begin
                    if (step_q == LAST) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // State registers; reset discards any tile in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tile_q  <= tile_d;
        end
    end

    // One decoder per lane, all driven from the registered tile and step.
    for (genvar r = 0; r < SIZE; r++) begin : g_lane
        tile_skew_lane #(
            .SIZE   (SIZE),
            .STEP_W (STEP_W),
            .ROW    (r)
        ) u_lane (
            .en   (streaming),
            .step (step_q),
            .row  (tile_q[r]),
            .vld  (lane_valid[r]),
            .data (lane_data[r])
        );
    end

endmodule
